pipe_control: RTL

Parametrised pipeline controller replacing the fixed-stall controller. It sits between the IF/ID register and the datapath control lines. It decodes the 3-bit opcode of the IF/ID instruction and issues it only when no in-flight instruction still owes a write to one of its source registers. A scoreboard of depth PIPE_DEPTH tracks in-flight writes, and a counter inserts a configurable number of branch-resolution bubbles after each BEQ.

---
 rtl/pipe_ctrl_pkg.sv | 128 ++++++++++++
 rtl/pipe_scoreboard.sv | 66 ++++++
 rtl/pipe_control.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared definitions for the pipeline controller: opcode and ALUOp
//   encodings, IF/ID field positions, controller state enum, scoreboard
//   entry type, control bundle and the instruction decode helper.
//   Feature macro: PIPE_CTRL_INTERLOCK_EN (scoreboard interlock vs legacy
//   fixed-bubble mode) is consumed by pipe_control and pipe_scoreboard.
package pipe_ctrl_pkg;

  // Opcodes
  localparam logic [2:0] OP_RTYPE = 3'd0;
  localparam logic [2:0] OP_BEQ   = 3'd2;
  localparam logic [2:0] OP_ADDI  = 3'd3;
  localparam logic [2:0] OP_LW    = 3'd5;
  localparam logic [2:0] OP_SW    = 3'd6;

  // ALUOp encodings
  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  // IF/ID field bit positions
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int RS_MSB  = 12;
  localparam int RS_LSB  = 10;
  localparam int RT_MSB  = 9;
  localparam int RT_LSB  = 7;
  localparam int RD_MSB  = 6;
  localparam int RD_LSB  = 4;

  // Bubble counter width; holds up to PIPE_DEPTH = 8
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_RUN     = 2'd1,
    ST_BR_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] dest;
  } sb_entry_t;

  typedef struct packed {
    logic       pc_stall;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src;
    logic       branch;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    ctrl_t      ctrl;
    logic       is_nop;
    logic       reads_rs;
    logic       reads_rt;
    logic       writes;
    logic [2:0] dest;
    logic [2:0] rs;
    logic [2:0] rt;
  } decode_t;

  localparam ctrl_t CTRL_NONE   = ctrl_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
  localparam ctrl_t CTRL_BUBBLE = ctrl_t'{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};

  // Decode one IF/ID word into controls, source-read flags and destination.
  function automatic decode_t decode_instr(input logic [15:0] instr);
    decode_t    dec;
    logic [2:0] opc;
    opc           = instr[OPC_MSB:OPC_LSB];
    dec           = '0;
    dec.ctrl      = CTRL_NONE;
    dec.rs        = instr[RS_MSB:RS_LSB];
    dec.rt        = instr[RT_MSB:RT_LSB];
    case (opc)
      OP_RTYPE: begin
        dec.reads_rs       = 1'b1;
        dec.reads_rt       = 1'b1;
        dec.writes         = 1'b1;
        dec.dest           = instr[RD_MSB:RD_LSB];
        dec.ctrl.reg_write = 1'b1;
        dec.ctrl.reg_dst   = 1'b1;
        dec.ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_BEQ: begin
        dec.reads_rs       = 1'b1;
        dec.reads_rt       = 1'b1;
        dec.ctrl.branch    = 1'b1;
        dec.ctrl.alu_op    = ALUOP_SUB;
      end
      OP_ADDI: begin
        dec.reads_rs       = 1'b1;
        dec.writes         = 1'b1;
        dec.dest           = instr[RT_MSB:RT_LSB];
        dec.ctrl.reg_write = 1'b1;
        dec.ctrl.alu_src   = 1'b1;
        dec.ctrl.alu_op    = ALUOP_ADD;
      end
      OP_LW: begin
        dec.reads_rs        = 1'b1;
        dec.writes          = 1'b1;
        dec.dest            = instr[RT_MSB:RT_LSB];
        dec.ctrl.reg_write  = 1'b1;
        dec.ctrl.alu_src    = 1'b1;
        dec.ctrl.mem_read   = 1'b1;
        dec.ctrl.mem_to_reg = 1'b1;
        dec.ctrl.alu_op     = ALUOP_ADD;
      end
      OP_SW: begin
        dec.reads_rs       = 1'b1;
        dec.reads_rt       = 1'b1;
        dec.ctrl.alu_src   = 1'b1;
        dec.ctrl.mem_write = 1'b1;
        dec.ctrl.alu_op    = ALUOP_ADD;
      end
      default: begin
        dec.is_nop = 1'b1;
      end
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard
//   Shift-register scoreboard of in-flight register writes. Slot 0 takes
//   the entry issued this cycle (invalid on a bubble or nop); each slot ages
//   by one per cycle and the oldest is dropped. hit reports a valid slot
//   whose destination matches an enabled, non-zero source address.
//   Ports: clock, reset (sync, active-high), shift_in, rs_addr/rs_en,
//          rt_addr/rt_en, hit.
//   Present only when PIPE_CTRL_INTERLOCK_EN is defined.
`ifdef PIPE_CTRL_INTERLOCK_EN
module pipe_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int PIPE_DEPTH = 3
) (
  input  logic      clock,
  input  logic      reset,
  input  sb_entry_t shift_in,
  input  logic [2:0] rs_addr,
  input  logic      rs_en,
  input  logic [2:0] rt_addr,
  input  logic      rt_en,
  output logic      hit
);

  sb_entry_t slot_q [PIPE_DEPTH];
  sb_entry_t slot_d [PIPE_DEPTH];
  logic      rs_live_s;
  logic      rt_live_s;

  // r0 is hardwired zero, so reading it never waits on a producer
  assign rs_live_s = rs_en & (rs_addr != 3'd0);
  assign rt_live_s = rt_en & (rt_addr != 3'd0);

  // Next slot contents: new entry at the head, everything else ages by one
  always_comb begin
    slot_d[0] = shift_in;
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      slot_d[k] = slot_q[k-1];
    end
  end

  // Slot registers, invalidated on reset
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  // Any valid slot matching a live source register is a hazard
  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      hit = hit | (slot_q[k].valid &
                   ((rs_live_s & (slot_q[k].dest == rs_addr)) |
                    (rt_live_s & (slot_q[k].dest == rt_addr))));
    end
  end

endmodule
`endif

// File: rtl/pipe_control.sv
// pipe_control
//   Pipeline issue controller between IF/ID and the datapath control lines.
//   Decodes IFID, issues its controls or a bubble (PCStall=1, rest 0), and
//   inserts bubbles after branches (interlock build) or after every issued
//   instruction (legacy build).
//   Ports: clock, reset (sync, active-high), IFID[15:0] in;
//          PCStall, RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemRead,
//          MemtoReg, ALUOp[1:0], HazardStall out (combinational).
//   Macro PIPE_CTRL_INTERLOCK_EN: defined -> scoreboard interlock with
//   BRANCH_STALLS bubbles after BEQ; undefined -> legacy PIPE_DEPTH bubbles
//   after every issued non-nop, HazardStall tied low.
module pipe_control
  import pipe_ctrl_pkg::*;
#(
  parameter int PIPE_DEPTH    = 3,
  parameter int BRANCH_STALLS = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] IFID,
  output logic        PCStall,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        ALUSrc,
  output logic        Branch,
  output logic        MemWrite,
  output logic        MemRead,
  output logic        MemtoReg,
  output logic [1:0]  ALUOp,
  output logic        HazardStall
);

  localparam logic [CNT_W-1:0] BR_CNT = CNT_W'(BRANCH_STALLS);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  decode_t          dec_s;
  ctrl_t            ctrl_s;
  logic             hazard_s;
  logic             hazard_stall_s;
  logic             issue_s;

  assign dec_s = decode_instr(IFID);

`ifdef PIPE_CTRL_INTERLOCK_EN
  localparam logic BR_WAIT_EN = (BRANCH_STALLS > 0);

  sb_entry_t sb_in_s;
  logic      unused_s;

  // Writes to r0 are recorded as invalid so they never block a reader
  assign sb_in_s.valid = issue_s & dec_s.writes & (dec_s.dest != 3'd0);
  assign sb_in_s.dest  = dec_s.dest;
  assign unused_s      = ^IFID[3:0];

  pipe_scoreboard #(
    .PIPE_DEPTH(PIPE_DEPTH)
  ) u_scoreboard (
    .clock    (clock),
    .reset    (reset),
    .shift_in (sb_in_s),
    .rs_addr  (dec_s.rs),
    .rs_en    (dec_s.reads_rs),
    .rt_addr  (dec_s.rt),
    .rt_en    (dec_s.reads_rt),
    .hit      (hazard_s)
  );
`else
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(PIPE_DEPTH);

  logic unused_s;

  // Legacy mode never interlocks; register fields and BRANCH_STALLS have no consumer
  assign hazard_s = 1'b0;
  assign unused_s = ^{IFID, dec_s, BR_CNT};
`endif

  // Next state, bubble counter and control outputs
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ctrl_s         = CTRL_BUBBLE;
    hazard_stall_s = 1'b0;
    issue_s        = 1'b0;
    if (reset) begin
      ctrl_s = CTRL_BUBBLE;
    end else begin
      case (state_q)
        ST_RESET: begin
          ctrl_s  = CTRL_BUBBLE;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (hazard_s) begin
            ctrl_s         = CTRL_BUBBLE;
            hazard_stall_s = 1'b1;
          end else begin
            ctrl_s  = dec_s.ctrl;
            issue_s = ~dec_s.is_nop;
`ifdef PIPE_CTRL_INTERLOCK_EN
            if (issue_s && dec_s.ctrl.branch && BR_WAIT_EN) begin
              cnt_d   = BR_CNT;
              state_d = ST_BR_WAIT;
            end else begin
              state_d = ST_RUN;
            end
`else
            if (issue_s) begin
              cnt_d   = DEPTH_CNT;
              state_d = ST_BR_WAIT;
            end else begin
              state_d = ST_RUN;
            end
`endif
          end
        end
        ST_BR_WAIT: begin
          // Counter holds the bubbles still owed, this one included
          ctrl_s = CTRL_BUBBLE;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_BR_WAIT;
          end
        end
        default: begin
          ctrl_s  = CTRL_BUBBLE;
          cnt_d   = '0;
          state_d = ST_RESET;
        end
      endcase
    end
  end

  // State and counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PCStall     = ctrl_s.pc_stall;
  assign RegWrite    = ctrl_s.reg_write;
  assign RegDst      = ctrl_s.reg_dst;
  assign ALUSrc      = ctrl_s.alu_src;
  assign Branch      = ctrl_s.branch;
  assign MemWrite    = ctrl_s.mem_write;
  assign MemRead     = ctrl_s.mem_read;
  assign MemtoReg    = ctrl_s.mem_to_reg;
  assign ALUOp       = ctrl_s.alu_op;
  assign HazardStall = hazard_stall_s;

endmodule
